// File: rtl/dmac_dest_fifo_inf.sv
// dmac_dest_fifo_inf
// Destination-side FIFO interface of the DMA controller. Accepts the
// controller's valid/ready data stream and hands one word per en strobe to a
// pull-style consumer (e.g. a DAC), flagging underflow when a strobe finds no
// data. Beats are counted into bursts (full bursts of C_BEATS_PER_BURST, or a
// short final burst qualified by eot). Each completed burst advances
// response_id so that the request side can retire it.
//
// Optional feature: define DMAC_DEST_UNDERFLOW_CNT_EN to add a saturating
// 16-bit underflow_count output. The counter clears on reset and on every
// rising edge of enable.
module dmac_dest_fifo_inf #(
    parameter int C_ID_WIDTH        = 3,
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_BEATS_PER_BURST = 16
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    enable,
    output logic                    enabled,

    input  logic                    sync_id,
    output logic                    sync_id_ret,

    input  logic [C_ID_WIDTH-1:0]   request_id,
    output logic [C_ID_WIDTH-1:0]   response_id,
    input  logic                    eot,

    input  logic                    en,
    output logic [C_DATA_WIDTH-1:0] dout,
    output logic                    valid,
    output logic                    underflow,

    input  logic                    fifo_valid,
    output logic                    fifo_ready,
    input  logic [C_DATA_WIDTH-1:0] fifo_data,

`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
    output logic [15:0]             underflow_count,
`endif

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_last_burst_length
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0]            LAST_BEAT = 4'(C_BEATS_PER_BURST - 1);
    localparam logic [C_ID_WIDTH-1:0] ID_ONE    = C_ID_WIDTH'(1);

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              beat_cnt;
    logic [3:0]              last_len;

    logic                    pending;
    logic                    beat;
    logic                    eot_last;
    logic                    burst_last;
    logic                    disable_now;
    logic [C_ID_WIDTH-1:0]   id_plus_one;

    // Handshake and burst-boundary decode.
    assign sync_id_ret = sync_id;
    assign pending     = (response_id != request_id);
    assign fifo_ready  = en & enabled & pending & (state == ACTIVE);
    assign beat        = fifo_valid & fifo_ready;
    assign id_plus_one = response_id + ID_ONE;
    assign eot_last    = eot & (id_plus_one == request_id) & (beat_cnt == last_len);
    assign burst_last  = beat & ((beat_cnt == LAST_BEAT) | eot_last);
    assign req_ready   = (state == IDLE) & enable & enabled;

    // Once enable drops, shut down as soon as no burst is left half-done.
    // A beat landing on beat_cnt==0 starts a burst, so only its completion
    // may end it.
    assign disable_now = ~enable & (beat ? burst_last : (beat_cnt == 4'd0));

    // Next-state logic: take a request in IDLE, return on the eot-final beat
    // or when a disable is allowed to take effect.
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and
        // no latch is inferred.
        state_next = state;
        case (state)
            IDLE:   if (req_valid & req_ready) state_next = ACTIVE;
            ACTIVE: if (burst_last & eot_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (disable_now) state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // enabled follows enable, but is held high until the running burst ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          enabled <= 1'b0;
        else if (enable)      enabled <= 1'b1;
        else if (disable_now) enabled <= 1'b0;
    end

    // Burst tracking: beat counter, final-burst length and completion ID.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt    <= 4'd0;
            last_len    <= 4'd0;
            response_id <= '0;
        end else begin
            if (req_valid & req_ready) last_len <= req_last_burst_length;

            if (burst_last) begin
                beat_cnt    <= 4'd0;
                response_id <= id_plus_one;
            end else if (beat) begin
                beat_cnt    <= beat_cnt + 4'd1;
            end else if ((state == IDLE) & sync_id & enable) begin
                // Resynchronise and drop any stale pending bursts.
                response_id <= request_id;
            end
        end
    end

    // Registered read port: one cycle from en to dout/valid/underflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout      <= '0;
            valid     <= 1'b0;
            underflow <= 1'b0;
        end else if (en & beat) begin
            dout      <= fifo_data;
            valid     <= 1'b1;
            underflow <= 1'b0;
        end else if (en) begin
            valid     <= 1'b0;
            underflow <= enabled;
        end else begin
            valid     <= 1'b0;
            underflow <= 1'b0;
        end
    end

`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
    logic enable_d;

    // Saturating underflow counter, cleared on each new enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_d        <= 1'b0;
            underflow_count <= 16'd0;
        end else begin
            enable_d <= enable;
            if (enable & ~enable_d)
                underflow_count <= 16'd0;
            else if (underflow && underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule
